// File: rtl/fp_arith_pkg.sv
// Shared arithmetic definitions for the digit-serial subtractor: default
// widths, the slice count and the controller state encoding.
package fp_arith_pkg;

   localparam int DATA_W_DEF  = 24;
   localparam int SLICE_W_DEF = 6;
   localparam int NSLICE_DEF  = DATA_W_DEF / SLICE_W_DEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } sub_state_e;

   // Counter width for a given slice count; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sub_24bits_seq_if.sv
// Operand/result handshake bundle of the digit-serial subtractor.
// The slave side is the subtractor itself, the master side its user.
interface sub_24bits_seq_if
   import fp_arith_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) ();

   logic              i_valid;
   logic              o_ready;
   logic [DATA_W-1:0] i_data_one;
   logic [DATA_W-1:0] i_data_two;
   logic              i_borrow;
   logic              o_valid;
   logic              i_ready;
   logic [DATA_W-1:0] o_data;
   logic              o_borrow;
   logic              o_zero;

   modport slave (
      input  i_valid, i_data_one, i_data_two, i_borrow, i_ready,
      output o_ready, o_valid, o_data, o_borrow, o_zero
   );

   modport master (
      output i_valid, i_data_one, i_data_two, i_borrow, i_ready,
      input  o_ready, o_valid, o_data, o_borrow, o_zero
   );

endinterface

// File: rtl/sub_6bits.sv
// Combinational slice subtractor: o_data = a - b - borrow_in (mod 2^W),
// o_borrow set when the true difference is negative.
module sub_6bits
   import fp_arith_pkg::*;
#(
   parameter int W = SLICE_W_DEF
) (
   input  logic [W-1:0] i_data_one,
   input  logic [W-1:0] i_data_two,
   input  logic         i_borrow,
   output logic [W-1:0] o_data,
   output logic         o_borrow
);

   logic [W:0] diff_ext;

   // One guard bit above the slice catches the borrow-out as the sign.
   assign diff_ext = {1'b0, i_data_one} - {1'b0, i_data_two} - {{W{1'b0}}, i_borrow};
   assign o_data   = diff_ext[W-1:0];
   assign o_borrow = diff_ext[W];

endmodule

// File: rtl/sub_24bits_seq.sv
// Digit-serial subtractor: one SLICE_W-bit slice per cycle, LSB first,
// with the borrow carried between slices in a register.
//
//   state | meaning
//   IDLE  | ready for operands; accept latches a, b and borrow-in
//   CALC  | slice cnt_q is subtracted each cycle, borrow ripples via borrow_q
//   DONE  | result, borrow-out and zero flag held until downstream takes them
module sub_24bits_seq
   import fp_arith_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int SLICE_W = SLICE_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   sub_24bits_seq_if.slave  bus
);

   localparam int NSLICE = DATA_W / SLICE_W;
   localparam int CNT_W  = cnt_width(NSLICE);
   localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

   sub_state_e         state_q;
   sub_state_e         state_d;
   logic [DATA_W-1:0]  op_one_q;
   logic [DATA_W-1:0]  op_two_q;
   logic [DATA_W-1:0]  res_q;
   logic [DATA_W-1:0]  res_d;
   logic               borrow_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               out_borrow_q;
   logic               zero_q;
   logic [SLICE_W-1:0] slice_one;
   logic [SLICE_W-1:0] slice_two;
   logic [SLICE_W-1:0] slice_diff;
   logic               slice_borrow;
   logic               last_slice;

   assign last_slice = (cnt_q == LAST_SLICE);

   // Select the operand slices addressed by the slice counter.
   always_comb begin
      slice_one = op_one_q[cnt_q*SLICE_W +: SLICE_W];
      slice_two = op_two_q[cnt_q*SLICE_W +: SLICE_W];
   end

   sub_6bits #(
      .W (SLICE_W)
   ) u_slice (
      .i_data_one (slice_one),
      .i_data_two (slice_two),
      .i_borrow   (borrow_q),
      .o_data     (slice_diff),
      .o_borrow   (slice_borrow)
   );

   // Result with the current slice merged in; also feeds the zero detect.
   always_comb begin
      res_d = res_q;
      res_d[cnt_q*SLICE_W +: SLICE_W] = slice_diff;
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.i_valid) state_d = CALC;
         CALC:    if (last_slice)  state_d = DONE;
         DONE:    if (bus.i_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand capture, per-slice datapath update and result flags.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         op_one_q     <= '0;
         op_two_q     <= '0;
         res_q        <= '0;
         borrow_q     <= 1'b0;
         cnt_q        <= '0;
         out_borrow_q <= 1'b0;
         zero_q       <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.i_valid) begin
                  op_one_q <= bus.i_data_one;
                  op_two_q <= bus.i_data_two;
                  borrow_q <= bus.i_borrow;
                  cnt_q    <= '0;
               end
            end
            CALC: begin
               res_q    <= res_d;
               borrow_q <= slice_borrow;
               if (last_slice) begin
                  cnt_q        <= '0;
                  out_borrow_q <= slice_borrow;
                  zero_q       <= (res_d == '0);
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Handshake flags come straight from the state register.
   assign bus.o_ready  = (state_q == IDLE);
   assign bus.o_valid  = (state_q == DONE);
   assign bus.o_data   = res_q;
   assign bus.o_borrow = out_borrow_q;
   assign bus.o_zero   = zero_q;

endmodule
